pkt_tx_framer: RTL and testbench
================================

// Module: pkt_tx_framer
// PURPOSE
//  Transmit-side framer for the node. It latches the outgoing packet fields that rewardv2
//  produces (r* outputs, start = reward_done) and serializes them as a 16-bit word stream
//  with a valid/ready handshake towards the radio/MAC interface. It reports TX completion
//  and computes the transmit energy cost. It is the counterpart of the packet filter,
//  which supplies the f* fields to rewardv2.
// PARAMETERS
//  WORD_WIDTH  16       data/field width
//  HB_LEN      4        words in a heartbeat packet (type 3'b000)
//  FULL_LEN    8        words in every other valid packet (types 3'b001..3'b101)
//  COST_H1     16'h0005 TX energy cost, 1 hop;   COST_H2 16'h0009 TX energy cost, 2 hops
//  COST_H3     16'h0011 TX energy cost, 3 hops;  COST_H4 16'h001b TX energy cost, 4 or more hops
// PORTS
//  clk             in   1   clock, rising edge
//  nrst            in   1   asynchronous active-low reset
//  en              in   1   start pulse (driven by reward_done); fields are sampled on this cycle
//  tx_setting      in   1   0 = intra-cluster (1-hop cost); 1 = route cost indexed by rHopsFromCH
//  rPacketType     in   3   packet type
//  rTimeslot       in   6   assigned timeslot
//  rSourceID, rDestinationID, rSourceHops, rQValue, rEnergyLeft, rChosenCH, rHopsFromCH
//                  in   16  each: packet fields
//  myEnergy        in   16  node residual energy (used only with TX_NRG_DEBIT_EN)
//  tx_ready        in   1   sink accepts tx_data on this cycle
//  tx_data         out  16  current word
//  tx_valid        out  1   tx_data is valid
//  tx_last         out  1   current word is the final word of the packet
//  tx_busy         out  1   a packet is in flight (state is not IDLE)
//  tx_done         out  1   1-cycle pulse after the last word is accepted
//  tx_drop         out  1   1-cycle pulse: start rejected (invalid type, or en while busy)
//  tx_cost         out  16  energy cost of the latched packet
//  nrg_update      out  1   1-cycle pulse with tx_done when TX_NRG_DEBIT_EN is defined; else tied 0
//  nrgAfterTx      out  16  myEnergy minus tx_cost, saturating at 0; else tied 0
// BEHAVIOUR
//  - Reset: state = IDLE; every output = 0; the field latches and word index are cleared.
//    A reset asserted mid-packet aborts the packet, and no tx_done is produced for it.
//  - FSM states IDLE, SEND, DONE.
//    IDLE -> SEND on en with rPacketType <= 3'b101; all fields and tx_setting are latched.
//    IDLE, en with type 3'b110 or 3'b111 -> tx_drop pulse next cycle; stay in IDLE.
//  - Word format:
//    W0 = {rPacketType, 7'b0, rTimeslot}; W1 = SourceID; W2 = DestinationID; W3 = SourceHops;
//    W4 = QValue; W5 = EnergyLeft; W6 = ChosenCH; W7 = HopsFromCH.
//    A heartbeat sends W0..W3 only.
//  - Latency: en in cycle N gives tx_valid=1 carrying W0 in cycle N+1.
//  - Handshake: the word index advances only when tx_valid && tx_ready. tx_data and tx_valid
//    hold stable while tx_ready=0. There is no limit on stall length.
//  - tx_last = 1 with word HB_LEN-1 (heartbeat) or word FULL_LEN-1 (other types).
//    When that word is accepted, go to DONE.
//  - DONE: tx_done=1, tx_valid=0, for one cycle, then IDLE. A new en is accepted from IDLE only.
//  - en during SEND or DONE: ignored; the latched fields are unchanged; tx_drop pulses next cycle.
//  - tx_cost is computed at latch time and held until the next accepted start.
//    tx_setting=0 -> COST_H1.
//    tx_setting=1 -> rHopsFromCH 0 or 1 -> COST_H1; 2 -> COST_H2; 3 -> COST_H3; >=4 -> COST_H4
//    (this includes 16'hFFFF).
//  - The word index is a 3-bit counter and never wraps past the packet length.
// CONFIGURATION
//  - TX_NRG_DEBIT_EN defined:
//    - On the tx_done cycle: nrgAfterTx = (myEnergy >= tx_cost) ? myEnergy - tx_cost : 0,
//      sampled on that cycle.
//    - nrg_update pulses with tx_done.
//    - nrgAfterTx holds its value until the next update.
//  - TX_NRG_DEBIT_EN undefined:
//    - nrg_update and nrgAfterTx are constant 0; myEnergy is unused.
//    - Framing is identical.
// TESTING
//  1. Heartbeat: type 000, timeslot 6'd5, src 16'h000c, dest 0, hops 1, tx_ready=1.
//     -> 4 words 16'h0005, 16'h000c, 16'h0000, 16'h0001, starting 1 cycle after en.
//     -> tx_last on the 4th word; tx_done on the next cycle; tx_cost=16'h0005.
//  2. Type 001, tx_setting=1, rHopsFromCH=3, tx_ready toggling 1/0 each cycle.
//     -> 8 words in order, each held through its stall; tx_cost=16'h0011.
//  3. Type 111 with en -> tx_drop pulse; tx_valid stays 0; tx_busy stays 0.
//  4. en again during SEND -> tx_drop pulse; remaining words unchanged; exactly one tx_done.
//  5. nrst=0 on word 3 of an 8-word packet, then release.
//     -> all outputs 0; no tx_done; the next en starts cleanly at W0.
//  6. TX_NRG_DEBIT_EN, myEnergy=16'h7ffc, cost 16'h001b -> nrgAfterTx=16'h7fe1 with nrg_update.
//     myEnergy=16'h0003 -> nrgAfterTx=16'h0000.

Source files
------------

// File: rtl/pkt_tx_framer.sv
// Transmit framer: latches the packet fields and sends them as 16-bit words over valid/ready.
// Optional TX energy debit (nrg_update, nrgAfterTx) is built only when TX_NRG_DEBIT_EN is defined.
module pkt_tx_framer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned HB_LEN     = 4,
  parameter int unsigned FULL_LEN   = 8,
  parameter logic [WORD_WIDTH-1:0] COST_H1 = 16'h0005,
  parameter logic [WORD_WIDTH-1:0] COST_H2 = 16'h0009,
  parameter logic [WORD_WIDTH-1:0] COST_H3 = 16'h0011,
  parameter logic [WORD_WIDTH-1:0] COST_H4 = 16'h001b
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  tx_setting,
  input  logic [2:0]            rPacketType,
  input  logic [5:0]            rTimeslot,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_drop,
  output logic [WORD_WIDTH-1:0] tx_cost,
  output logic                  nrg_update,
  output logic [WORD_WIDTH-1:0] nrgAfterTx
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [2:0] HB_LAST   = 3'(HB_LEN - 1);
  localparam logic [2:0] FULL_LAST = 3'(FULL_LEN - 1);

  state_t state, state_nxt;

  logic [2:0]            lat_type;
  logic [5:0]            lat_slot;
  logic [WORD_WIDTH-1:0] lat_src, lat_dst, lat_shops, lat_q, lat_nrg, lat_ch, lat_hops;
  logic [2:0]            idx;
  logic [2:0]            last_idx;
  logic                  start_ok;
  logic                  at_last;
  logic [WORD_WIDTH-1:0] cost_calc;
  logic [WORD_WIDTH-1:0] word_sel;

  assign start_ok = en && (rPacketType <= 3'b101);
  assign last_idx = (lat_type == 3'b000) ? HB_LAST : FULL_LAST;
  assign at_last  = (idx == last_idx);

  // Route cost saturates at the 4-hop figure for any larger hop count.
  always_comb begin
    cost_calc = COST_H1;
    if (tx_setting) begin
      if (rHopsFromCH <= 1)      cost_calc = COST_H1;
      else if (rHopsFromCH == 2) cost_calc = COST_H2;
      else if (rHopsFromCH == 3) cost_calc = COST_H3;
      else                       cost_calc = COST_H4;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SEND;
      SEND:    if (tx_ready && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lat_type  <= '0;
      lat_slot  <= '0;
      lat_src   <= '0;
      lat_dst   <= '0;
      lat_shops <= '0;
      lat_q     <= '0;
      lat_nrg   <= '0;
      lat_ch    <= '0;
      lat_hops  <= '0;
      idx       <= '0;
      tx_cost   <= '0;
      tx_drop   <= 1'b0;
    end else begin
      tx_drop <= en && ((state != IDLE) || (rPacketType > 3'b101));
      if (state == IDLE && start_ok) begin
        lat_type  <= rPacketType;
        lat_slot  <= rTimeslot;
        lat_src   <= rSourceID;
        lat_dst   <= rDestinationID;
        lat_shops <= rSourceHops;
        lat_q     <= rQValue;
        lat_nrg   <= rEnergyLeft;
        lat_ch    <= rChosenCH;
        lat_hops  <= rHopsFromCH;
        idx       <= '0;
        tx_cost   <= cost_calc;
      end else if (state == SEND && tx_ready && !at_last) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    word_sel = '0;
    case (idx)
      3'd0: word_sel = {lat_type, {(WORD_WIDTH-9){1'b0}}, lat_slot};
      3'd1: word_sel = lat_src;
      3'd2: word_sel = lat_dst;
      3'd3: word_sel = lat_shops;
      3'd4: word_sel = lat_q;
      3'd5: word_sel = lat_nrg;
      3'd6: word_sel = lat_ch;
      3'd7: word_sel = lat_hops;
      default: word_sel = '0;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    tx_busy  = (state != IDLE);
    tx_done  = (state == DONE);
    if (state == SEND) begin
      tx_valid = 1'b1;
      tx_data  = word_sel;
      tx_last  = at_last;
    end
  end

`ifdef TX_NRG_DEBIT_EN
  logic [WORD_WIDTH-1:0] nrg_calc;
  logic [WORD_WIDTH-1:0] nrg_hold;

  assign nrg_calc = (myEnergy >= tx_cost) ? (myEnergy - tx_cost) : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)               nrg_hold <= '0;
    else if (state == DONE)  nrg_hold <= nrg_calc;
  end

  // The fresh result is visible on the tx_done cycle itself, then held.
  assign nrg_update = (state == DONE);
  assign nrgAfterTx = (state == DONE) ? nrg_calc : nrg_hold;
`else
  logic unused_energy;
  assign unused_energy = ^myEnergy;
  assign nrg_update    = 1'b0;
  assign nrgAfterTx    = '0;
`endif

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Scoreboard bench for pkt_tx_framer: stimulus pushes expected words/costs, a monitor pops and compares.
module tb_pkt_tx_framer;
  logic clk = 1'b0, nrst = 1'b0, en = 1'b0, tx_setting = 1'b0, tx_ready = 1'b0;
  logic [2:0]  rPacketType = '0;
  logic [5:0]  rTimeslot = '0;
  logic [15:0] rSourceID = '0, rDestinationID = '0, rSourceHops = '0, rQValue = '0;
  logic [15:0] rEnergyLeft = '0, rChosenCH = '0, rHopsFromCH = '0, myEnergy = '0;
  logic [15:0] tx_data, tx_cost, nrgAfterTx;
  logic        tx_valid, tx_last, tx_busy, tx_done, tx_drop, nrg_update;

  pkt_tx_framer dut (
    .clk(clk), .nrst(nrst), .en(en), .tx_setting(tx_setting),
    .rPacketType(rPacketType), .rTimeslot(rTimeslot),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rSourceHops(rSourceHops),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .myEnergy(myEnergy), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_drop(tx_drop), .tx_cost(tx_cost),
    .nrg_update(nrg_update), .nrgAfterTx(nrgAfterTx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] cost_q[$];
  logic [15:0] fv[7];  // src, dest, src hops, q, energy left, chosen CH, hops from CH
  int checks = 0, passes = 0;
  int done_cnt = 0, drop_cnt = 0, exp_done = 0, exp_drop = 0, acc_cnt = 0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [15:0] ref_cost(input logic setting, input logic [15:0] hops);
    int unsigned h;
    h = hops;
    if (!setting || h <= 1) return 16'd5;
    if (h == 2) return 16'd9;
    if (h == 3) return 16'd17;
    return 16'd27;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (nrst) begin
      if (tx_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          check("word_data", tx_data, exp_q[0].data);
          check("word_last", tx_last, exp_q[0].last);
          if (tx_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
      if (tx_done) begin
        logic [15:0] c;
        done_cnt++;
        check("done_valid_low", tx_valid, 1'b0);
        if (cost_q.size() == 0) fail_now("unexpected_done");
        else begin
          c = cost_q.pop_front();
          check("tx_cost", tx_cost, c);
`ifdef TX_NRG_DEBIT_EN
          check("nrg_update", nrg_update, 1'b1);
          check("nrg_after", nrgAfterTx, (myEnergy >= c) ? myEnergy - c : 16'd0);
`else
          check("nrg_tied", {nrg_update, nrgAfterTx}, 17'd0);
`endif
        end
      end
      if (tx_drop) drop_cnt++;
    end
  end

  task automatic rand_fields();
    for (int i = 0; i < 7; i++) fv[i] = 16'($urandom);
    case ($urandom_range(0, 6))
      0: fv[6] = 16'd0;
      1: fv[6] = 16'd1;
      2: fv[6] = 16'd2;
      3: fv[6] = 16'd3;
      4: fv[6] = 16'd4;
      5: fv[6] = 16'hFFFF;
      default: fv[6] = 16'($urandom);
    endcase
  endtask

  task automatic issue(input logic [2:0] t, input logic [5:0] ts, input logic setting,
                       input bit busy_now);
    word_t w;
    int    n;
    bit    accept;
    logic [15:0] w0;
    w0 = {t, 7'b0, ts};
    accept = !busy_now && (t <= 3'b101);
    @(posedge clk); #1;
    rPacketType = t; rTimeslot = ts; tx_setting = setting;
    rSourceID = fv[0]; rDestinationID = fv[1]; rSourceHops = fv[2]; rQValue = fv[3];
    rEnergyLeft = fv[4]; rChosenCH = fv[5]; rHopsFromCH = fv[6];
    en = 1'b1;
    if (accept) begin
      n = (t == 3'b000) ? 4 : 8;
      w.data = w0; w.last = 1'b0;
      exp_q.push_back(w);
      for (int i = 1; i < n; i++) begin
        w.data = fv[i-1];
        w.last = (i == n - 1);
        exp_q.push_back(w);
      end
      cost_q.push_back(ref_cost(setting, fv[6]));
      exp_done++;
    end else exp_drop++;
    @(posedge clk); #1;
    en = 1'b0;
    rPacketType = 3'($urandom); rTimeslot = 6'($urandom); tx_setting = 1'($urandom);
    rSourceID = 16'($urandom); rDestinationID = 16'($urandom); rHopsFromCH = 16'($urandom);
    @(negedge clk);
    if (accept) check("first_word", {tx_valid, tx_data}, {1'b1, w0});
    else if (busy_now) check("drop_busy", tx_drop, 1'b1);
    else check("drop_idle", {tx_drop, tx_valid, tx_busy}, 3'b100);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || tx_busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) fail_now("idle_timeout");
  endtask

  initial begin
    #1;
    check("reset_outputs",
          {tx_data, tx_valid, tx_last, tx_busy, tx_done, tx_drop, tx_cost, nrg_update, nrgAfterTx},
          54'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    // heartbeat
    ready_mode = 0;
    fv[0] = 16'h000c; fv[1] = 16'h0000; fv[2] = 16'h0001;
    fv[3] = 16'h1111; fv[4] = 16'h2222; fv[5] = 16'h3333; fv[6] = 16'h0002;
    issue(3'b000, 6'd5, 1'b0, 0);
    wait_idle();

    // full packet with stalls every other cycle
    ready_mode = 1;
    rand_fields(); fv[6] = 16'd3;
    issue(3'b001, 6'($urandom), 1'b1, 0);
    wait_idle();

    // invalid type from idle
    ready_mode = 0;
    rand_fields();
    issue(3'b111, 6'd1, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("invalid_stays_idle", {tx_valid, tx_busy}, 2'b00);

    // en during SEND
    ready_mode = 2;
    rand_fields();
    issue(3'b100, 6'($urandom), 1'b1, 0);
    rand_fields();
    issue(3'b010, 6'($urandom), 1'b1, 1);
    wait_idle();

    // reset mid-packet on word 3
    ready_mode = 0;
    begin
      int base, k;
      rand_fields();
      base = acc_cnt;
      issue(3'b011, 6'($urandom), 1'b0, 0);
      k = 0;
      while (acc_cnt < base + 3 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 100) fail_now("reset_word_timeout");
      check("word3_on_bus", {tx_valid, tx_data}, {1'b1, fv[2]});
      nrst = 1'b0;
      exp_q.delete();
      cost_q.delete();
      exp_done--;
      #1;
      check("abort_outputs",
            {tx_data, tx_valid, tx_last, tx_busy, tx_done, tx_drop, tx_cost, nrg_update, nrgAfterTx},
            54'd0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
    end
    rand_fields();
    issue(3'b101, 6'($urandom), 1'b1, 0);
    wait_idle();

    // energy debit, large and saturating
    myEnergy = 16'h7ffc;
    rand_fields(); fv[6] = 16'd7;
    issue(3'b001, 6'd9, 1'b1, 0);
    wait_idle();
    myEnergy = 16'h0003;
    rand_fields(); fv[6] = 16'hFFFF;
    issue(3'b010, 6'd9, 1'b1, 0);
    wait_idle();

    // randomized traffic
    for (int p = 0; p < 30; p++) begin
      logic [2:0] t;
      ready_mode = $urandom_range(0, 2);
      myEnergy = 16'($urandom);
      rand_fields();
      t = 3'($urandom);
      issue(t, 6'($urandom), 1'($urandom), 0);
      if (t <= 3'b101 && $urandom_range(0, 3) == 0) begin
        rand_fields();
        issue(3'($urandom), 6'($urandom), 1'($urandom), 1);
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("done_count", done_cnt, exp_done);
    check("drop_count", drop_cnt, exp_drop);
    check("queue_empty", exp_q.size() + cost_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
